avst_channel_adapter_pkt: RTL and testbench

Parametrised Avalon-ST channel adapter for the DMA master / bytes-to-packets path. It narrows the source channel field to the sink's channel width and classifies each packet once, at its startofpacket beat. Packets whose channel exceeds MAX_CHANNEL are discarded whole rather than beat by beat. Output is registered through a 2-entry skid buffer, giving full throughput and no combinational ready path from out_ready to in_ready.

---
 rtl/avst_pkg.sv | 22 ++
 rtl/avst_skid_buffer.sv | 66 ++++++
 rtl/avst_channel_adapter_pkt.sv | 121 ++++++++++++
 tb/tb_avst_channel_adapter_pkt.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avst_pkg.sv
// Shared types and helpers for the Avalon-ST channel adapter and its skid buffer.
package avst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

    // Skid entry width: payload, narrowed channel, SOP and EOP.
    function automatic int beat_width(input int dataW, input int chanW);
        return dataW + chanW + 2;
    endfunction

    // Saturating increment of a counter that is `width` bits wide (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input int width);
        logic [31:0] maxVal;
        maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (count >= maxVal) ? count : count + 32'd1;
    endfunction

endpackage

// File: rtl/avst_skid_buffer.sv
// Two-entry skid buffer with registered output and registered ready.
module avst_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_countNext;

    assign w_push = i_valid && r_ready;
    assign w_pop  = (r_count != 2'd0) && i_ready;

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + 2'd1;
            2'b01:   w_countNext = r_count - 2'd1;
            default: w_countNext = r_count;
        endcase
    end

    // Ready is computed from the next occupancy so it is a pure flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_ready <= (w_countNext != 2'd2);
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head <= r_tail;
                end else if (w_push) begin
                    r_head <= i_data;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= i_data;
                end else begin
                    r_tail <= i_data;
                end
            end
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_ready = r_ready;
    assign o_data  = r_head;

endmodule

// File: rtl/avst_channel_adapter_pkt.sv
// Avalon-ST channel adapter: classifies packets at SOP, drops out-of-range
// channels whole, narrows the channel and forwards through a skid buffer.
module avst_channel_adapter_pkt
    import avst_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int IN_CHANNEL_W  = 8,
    parameter int OUT_CHANNEL_W = 1,
    parameter int MAX_CHANNEL   = 0,
    parameter int DROP_CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic [DROP_CNT_W-1:0]    proto_err_count
);

    localparam int BEAT_W = beat_width(DATA_W, OUT_CHANNEL_W);

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [OUT_CHANNEL_W-1:0] r_chan;
    logic [DROP_CNT_W-1:0]    r_dropCount;
    logic [DROP_CNT_W-1:0]    r_errCount;

    logic                     w_accept;
    logic                     w_chanOk;
    logic                     w_fwd;
    logic                     w_latch;
    logic                     w_dropInc;
    logic                     w_errInc;
    logic [OUT_CHANNEL_W-1:0] w_beatChan;
    logic [BEAT_W-1:0]        w_inBeat;
    logic [BEAT_W-1:0]        w_outBeat;

    assign w_accept = in_valid && in_ready;
    assign w_chanOk = $unsigned(32'(in_channel)) <= $unsigned(32'(MAX_CHANNEL));

    // Any SOP reclassifies the packet; a SOP outside IDLE is also a framing error.
    always_comb begin
        w_stateNext = r_state;
        w_fwd       = 1'b0;
        w_latch     = 1'b0;
        w_dropInc   = 1'b0;
        w_errInc    = 1'b0;
        if (w_accept) begin
            if (in_startofpacket) begin
                w_errInc = (r_state != ST_IDLE);
                if (w_chanOk) begin
                    w_fwd       = 1'b1;
                    w_latch     = 1'b1;
                    w_stateNext = in_endofpacket ? ST_IDLE : ST_PASS;
                end else begin
                    w_dropInc   = 1'b1;
                    w_stateNext = in_endofpacket ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (r_state)
                    ST_PASS: begin
                        w_fwd = 1'b1;
                        if (in_endofpacket) w_stateNext = ST_IDLE;
                    end
                    ST_DROP: begin
                        if (in_endofpacket) w_stateNext = ST_IDLE;
                    end
                    default: begin
                        w_errInc    = 1'b1;
                        w_stateNext = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_chan      <= '0;
            r_dropCount <= '0;
            r_errCount  <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_latch) r_chan <= in_channel[OUT_CHANNEL_W-1:0];
            if (w_dropInc) r_dropCount <= DROP_CNT_W'(sat_inc(32'(r_dropCount), DROP_CNT_W));
            if (w_errInc) r_errCount <= DROP_CNT_W'(sat_inc(32'(r_errCount), DROP_CNT_W));
        end
    end

    assign w_beatChan = in_startofpacket ? in_channel[OUT_CHANNEL_W-1:0] : r_chan;
    assign w_inBeat   = {in_data, w_beatChan, in_startofpacket, in_endofpacket};

    avst_skid_buffer #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_valid(w_fwd),
        .o_ready(in_ready),
        .i_data (w_inBeat),
        .o_valid(out_valid),
        .i_ready(out_ready),
        .o_data (w_outBeat)
    );

    assign {out_data, out_channel, out_startofpacket, out_endofpacket} = w_outBeat;
    assign drop_count      = r_dropCount;
    assign proto_err_count = r_errCount;

endmodule

// File: tb/tb_avst_channel_adapter_pkt.sv
// Scoreboard bench for avst_channel_adapter_pkt with a packet-level reference model.
// A 2-bit out channel with MAX_CHANNEL=2 exercises full-width compare vs truncation.
module tb_avst_channel_adapter_pkt;

    localparam int DATA_W        = 8;
    localparam int IN_CHANNEL_W  = 8;
    localparam int OUT_CHANNEL_W = 2;
    localparam int MAX_CHANNEL   = 2;
    localparam int DROP_CNT_W    = 3;
    localparam int CNT_MAX       = (1 << DROP_CNT_W) - 1;

    logic                     clk;
    logic                     reset;
    logic                     in_ready;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic [IN_CHANNEL_W-1:0]  in_channel;
    logic                     in_startofpacket;
    logic                     in_endofpacket;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [OUT_CHANNEL_W-1:0] out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic [DROP_CNT_W-1:0]    drop_count;
    logic [DROP_CNT_W-1:0]    proto_err_count;

    typedef struct {
        logic [DATA_W-1:0]        data;
        logic [OUT_CHANNEL_W-1:0] chan;
        logic                     sop;
        logic                     eop;
    } beat_t;

    beat_t sb[$];
    int    nChecks = 0;
    int    nFails  = 0;
    int    expDrop = 0;
    int    expErr  = 0;
    bit    modelInPkt = 0;
    bit    modelKeep  = 0;
    int    modelChan  = 0;
    int    readyMode  = 0;
    bit    monArmed   = 0;

    avst_channel_adapter_pkt #(
        .DATA_W       (DATA_W),
        .IN_CHANNEL_W (IN_CHANNEL_W),
        .OUT_CHANNEL_W(OUT_CHANNEL_W),
        .MAX_CHANNEL  (MAX_CHANNEL),
        .DROP_CNT_W   (DROP_CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_channel      (out_channel),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .drop_count       (drop_count),
        .proto_err_count  (proto_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            if (nFails <= 40)
                $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    function automatic int satInc(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    // Packet-level reference: one disposition per packet, decided at its SOP.
    task automatic modelBeat(input logic [DATA_W-1:0] d, input int ch, input bit sop, input bit eop);
        beat_t b;
        if (sop) begin
            if (modelInPkt) expErr = satInc(expErr);
            modelKeep = (ch <= MAX_CHANNEL);
            if (modelKeep) modelChan = ch % (1 << OUT_CHANNEL_W);
            else expDrop = satInc(expDrop);
            modelInPkt = !eop;
        end else if (!modelInPkt) begin
            expErr = satInc(expErr);
            return;
        end else if (eop) begin
            modelInPkt = 0;
        end
        if (modelKeep) begin
            b.data = d;
            b.chan = OUT_CHANNEL_W'(modelChan);
            b.sop  = sop;
            b.eop  = eop;
            sb.push_back(b);
        end
    endtask

    // Called at negedge+1; holds the beat until accepted (in_ready is stable here).
    task automatic applyStimulus(input logic [DATA_W-1:0] d, input int ch, input bit sop, input bit eop);
        int waitCycles = 0;
        in_valid         = 1'b1;
        in_data          = d;
        in_channel       = IN_CHANNEL_W'(ch);
        in_startofpacket = sop;
        in_endofpacket   = eop;
        while (!in_ready && waitCycles < 64) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        else modelBeat(d, ch, sop, eop);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic sendPacket(input int len, input int ch, input bit withEop, input int gapMax);
        for (int i = 0; i < len; i++) begin
            applyStimulus(DATA_W'($urandom), ch, i == 0, withEop && (i == len - 1));
            if (gapMax > 0) idleCycles($urandom_range(0, gapMax));
        end
    endtask

    task automatic applyReset(input int cycles);
        reset      = 1'b1;
        in_valid   = 1'b0;
        sb.delete();
        expDrop    = 0;
        expErr     = 0;
        modelInPkt = 0;
        modelKeep  = 0;
        repeat (cycles) begin
            @(negedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Monitor: picks out_ready for the coming edge, then checks the DUT state left by the last edge.
    initial begin
        int    cyc = 0;
        bit    prevStall = 0;
        beat_t prevBeat;
        out_ready = 1'b1;
        wait (monArmed);
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            if (reset) begin
                checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
                checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
                checkOutput("reset_out_data", 32'(out_data), 32'd0);
                checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
                checkOutput("reset_proto_err_count", 32'(proto_err_count), 32'd0);
                prevStall = 0;
            end else begin
                checkOutput("in_ready", 32'(in_ready), 32'(sb.size() < 2));
                checkOutput("out_valid", 32'(out_valid), 32'(sb.size() > 0));
                checkOutput("drop_count", 32'(drop_count), 32'(expDrop));
                checkOutput("proto_err_count", 32'(proto_err_count), 32'(expErr));
                if (prevStall) begin
                    checkOutput("stall_data", 32'(out_data), 32'(prevBeat.data));
                    checkOutput("stall_channel", 32'(out_channel), 32'(prevBeat.chan));
                end
                if (out_valid && sb.size() > 0) begin
                    checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
                    checkOutput("out_channel", 32'(out_channel), 32'(sb[0].chan));
                    checkOutput("out_sop", 32'(out_startofpacket), 32'(sb[0].sop));
                    checkOutput("out_eop", 32'(out_endofpacket), 32'(sb[0].eop));
                    if (out_ready) void'(sb.pop_front());
                end
                prevStall     = out_valid && !out_ready;
                prevBeat.data = out_data;
                prevBeat.chan = out_channel;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int drainCycles;
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_data          = '0;
        in_channel       = '0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        monArmed = 1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        idleCycles(1);

        $display("[TB] basic 4-beat packet on channel 0");
        readyMode = 0;
        sendPacket(4, 0, 1, 0);
        idleCycles(2);

        $display("[TB] dropped packet then passed packet");
        sendPacket(3, 5, 1, 0);
        sendPacket(2, 0, 1, 0);
        sendPacket(2, 6, 1, 0);
        sendPacket(3, 2, 1, 0);
        sendPacket(1, 8'h41, 1, 0);
        idleCycles(2);

        $display("[TB] non-SOP beat with foreign channel inside a packet");
        applyStimulus(8'h11, 0, 1, 0);
        applyStimulus(8'h22, 7, 0, 0);
        applyStimulus(8'h33, 0, 0, 1);
        idleCycles(2);

        $display("[TB] missing EOP and lone non-SOP beat");
        applyStimulus(8'h44, 0, 1, 0);
        applyStimulus(8'h55, 0, 0, 0);
        sendPacket(2, 1, 1, 0);
        applyStimulus(8'h66, 0, 0, 0);
        applyStimulus(8'h77, 1, 1, 0);
        applyStimulus(8'h88, 4, 1, 1);
        idleCycles(2);

        $display("[TB] 16-beat stream with out_ready pattern 1,0,0");
        readyMode = 1;
        sendPacket(16, 1, 1, 0);
        readyMode = 0;
        idleCycles(4);

        $display("[TB] reset in the middle of a packet");
        readyMode = 1;
        applyStimulus(8'h99, 0, 1, 0);
        applyStimulus(8'hAA, 0, 0, 0);
        applyReset(1);
        readyMode = 0;
        idleCycles(1);
        sendPacket(4, 2, 1, 0);
        idleCycles(2);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 9; i++) sendPacket(1, 3 + i, 1, 0);
        idleCycles(2);

        $display("[TB] randomized traffic");
        applyReset(2);
        idleCycles(1);
        for (int p = 0; p < 300; p++) begin
            int ch;
            int kind;
            readyMode = $urandom_range(0, 2);
            ch = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            kind = $urandom_range(0, 19);
            if (kind == 0) applyStimulus(DATA_W'($urandom), ch, 0, $urandom_range(0, 1) == 1);
            else sendPacket($urandom_range(1, 6), ch, kind != 1, $urandom_range(0, 1));
        end

        readyMode = 0;
        idleCycles(1);
        drainCycles = 0;
        while (sb.size() != 0 && drainCycles < 200) begin
            @(negedge clk);
            #1;
            drainCycles++;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
